// File: rtl/decoder_iinsn_load.sv
`default_nettype none
// ============================================================================
// Module      : decoder_iinsn_load
// Description : Control decoder for RV32I I-type LOAD instructions.
//               Produces datapath selects, clock-phase strobes, register
//               addresses, the sign-extended immediate and the load width
//               and sign controls. Purely combinational: there is no state.
//               Strobes are gated by RST_N and by the current CLK phase.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_iinsn_load (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSN,
  output logic        sub_sra,
  output logic        addr_sel,
  output logic        pc_next_sel,
  output logic        pc_alu_sel,
  output logic        rd_clk,
  output logic        mem_clk,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rs1_addr,
  output logic [31:0] imm,
  output logic [1:0]  ld_size,
  output logic        ld_unsigned,
  output logic        insn_valid,
  output logic        illegal
);

  localparam logic [6:0] c_opcode_load = 7'b0000011;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_is_load;
  logic       w_funct3_legal;
  logic       w_valid;

  assign w_opcode = INSN[6:0];
  assign w_funct3 = INSN[14:12];
  assign w_is_load = (w_opcode == c_opcode_load);

  // Classify funct3: only LB, LH, LW, LBU and LHU exist for LOAD.
  always_comb begin
    w_funct3_legal = 1'b0;
    case (w_funct3)
      3'b000,
      3'b001,
      3'b010,
      3'b100,
      3'b101:  w_funct3_legal = 1'b1;
      default: w_funct3_legal = 1'b0;
    endcase
  end

  assign w_valid = w_is_load && w_funct3_legal;

  // Field extraction is unconditional so the register file and immediate
  // path can start early; reset does not hide these fields.
  always_comb begin
    rd_addr     = INSN[11:7];
    rs1_addr    = INSN[19:15];
    imm         = {{20{INSN[31]}}, INSN[31:20]};
    ld_size     = 2'b00;
    ld_unsigned = 1'b0;
    if (w_funct3_legal) begin
      ld_size     = INSN[13:12];
      ld_unsigned = INSN[14];
    end
  end

  // Strobes and selects: reset forces everything low immediately; a valid
  // load drives the address phase while CLK is low and writeback while high.
  always_comb begin
    sub_sra     = 1'b0;
    pc_next_sel = 1'b0;
    pc_alu_sel  = 1'b0;
    mem_clk     = 1'b0;
    addr_sel    = 1'b0;
    rd_clk      = 1'b0;
    insn_valid  = 1'b0;
    illegal     = 1'b0;
    if (RST_N) begin
      insn_valid = w_valid;
      illegal    = w_is_load && !w_funct3_legal;
      if (w_valid) begin
        addr_sel = ~CLK;
        rd_clk   = CLK;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_iinsn_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_iinsn_load
// Description : Self-checking bench for decoder_iinsn_load. Vector table
//               with expected fields, scoreboard queue, and hand-written
//               sequences for clock tracking and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_iinsn_load;

  logic        CLK;
  logic        RST_N;
  logic [31:0] INSN;
  logic        sub_sra, addr_sel, pc_next_sel, pc_alu_sel, rd_clk, mem_clk;
  logic [4:0]  rd_addr, rs1_addr;
  logic [31:0] imm;
  logic [1:0]  ld_size;
  logic        ld_unsigned, insn_valid, illegal;

  int total = 0;
  int bad   = 0;

  decoder_iinsn_load dut (
    .CLK(CLK), .RST_N(RST_N), .INSN(INSN),
    .sub_sra(sub_sra), .addr_sel(addr_sel), .pc_next_sel(pc_next_sel),
    .pc_alu_sel(pc_alu_sel), .rd_clk(rd_clk), .mem_clk(mem_clk),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .imm(imm), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .insn_valid(insn_valid), .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // gate = strobes active (valid load out of reset)
  typedef struct {
    logic [31:0] insn;
    logic        rst_n;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [1:0]  size;
    logic        uns;
    logic        valid;
    logic        ill;
    logic        gate;
  } vec_t;

  vec_t vecs [0:10];
  vec_t sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t insn=0x%08h clk=%0b rst_n=%0b)",
               name, act, exp, $time, INSN, CLK, RST_N);
    end
  endtask

  // Pop one expected record and compare every output against it,
  // with strobes derived from the sampled CLK phase.
  task automatic check_pop();
    vec_t e;
    logic c;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got=empty want=record");
      return;
    end
    e = sb_q.pop_front();
    c = CLK;
    chk("rd_addr",     {27'd0, rd_addr},     {27'd0, e.rd});
    chk("rs1_addr",    {27'd0, rs1_addr},    {27'd0, e.rs1});
    chk("imm",         imm,                  e.imm);
    chk("ld_size",     {30'd0, ld_size},     {30'd0, e.size});
    chk("ld_unsigned", {31'd0, ld_unsigned}, {31'd0, e.uns});
    chk("insn_valid",  {31'd0, insn_valid},  {31'd0, e.valid});
    chk("illegal",     {31'd0, illegal},     {31'd0, e.ill});
    chk("rd_clk",      {31'd0, rd_clk},      {31'd0, e.gate & c});
    chk("addr_sel",    {31'd0, addr_sel},    {31'd0, e.gate & ~c});
    chk("mem_clk",     {31'd0, mem_clk},     32'd0);
    chk("sub_sra",     {31'd0, sub_sra},     32'd0);
    chk("pc_next_sel", {31'd0, pc_next_sel}, 32'd0);
    chk("pc_alu_sel",  {31'd0, pc_alu_sel},  32'd0);
  endtask

  task automatic drive(input vec_t v);
    INSN  = v.insn;
    RST_N = v.rst_n;
    sb_q.push_back(v);
  endtask

  function automatic vec_t mk(input logic [31:0] insn, input logic rst_n,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] imm, input logic [1:0] size,
                              input logic uns, input logic valid,
                              input logic ill, input logic gate);
    vec_t v;
    v.insn = insn; v.rst_n = rst_n; v.rd = rd; v.rs1 = rs1; v.imm = imm;
    v.size = size; v.uns = uns; v.valid = valid; v.ill = ill; v.gate = gate;
    return v;
  endfunction

  vec_t lw_v;

  initial begin
    //          insn          rst rd  rs1 imm           sz    uns v  ill gate
    vecs[0]  = mk(32'h0087A803, 1, 16, 15, 32'h00000008, 2'b10, 0, 1, 0, 1); // lw x16,8(x15)
    vecs[1]  = mk(32'hFFC7C803, 1, 16, 15, 32'hFFFFFFFC, 2'b00, 1, 1, 0, 1); // lbu x16,-4(x15)
    vecs[2]  = mk(32'h0087B803, 1, 16, 15, 32'h00000008, 2'b00, 0, 0, 1, 0); // funct3 011
    vecs[3]  = mk(32'h0087A833, 1, 16, 15, 32'h00000008, 2'b10, 0, 0, 0, 0); // non-LOAD opcode
    vecs[4]  = mk(32'h800F9283, 1,  5, 31, 32'hFFFFF800, 2'b01, 0, 1, 0, 1); // lh x5,-2048(x31)
    vecs[5]  = mk(32'h7FF15083, 1,  1,  2, 32'h000007FF, 2'b01, 1, 1, 0, 1); // lhu x1,2047(x2)
    vecs[6]  = mk(32'h00000003, 1,  0,  0, 32'h00000000, 2'b00, 0, 1, 0, 1); // lb x0,0(x0)
    vecs[7]  = mk(32'h00006003, 1,  0,  0, 32'h00000000, 2'b00, 0, 0, 1, 0); // funct3 110
    vecs[8]  = mk(32'h00007003, 1,  0,  0, 32'h00000000, 2'b00, 0, 0, 1, 0); // funct3 111
    vecs[9]  = mk(32'h0087A803, 0, 16, 15, 32'h00000008, 2'b10, 0, 0, 0, 0); // lw under reset
    vecs[10] = mk(32'h0087B803, 0, 16, 15, 32'h00000008, 2'b00, 0, 0, 0, 0); // illegal under reset
    lw_v = vecs[0];

    // Reset state: strobes low, fields still track INSN.
    drive(vecs[9]);
    #1 check_pop();

    // Spec point: lw checked at t=10ns (sampled just after, CLK=0).
    drive(vecs[0]);
    @(negedge CLK); #1 check_pop();

    // Table: each vector checked in the high and low CLK phases.
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      #1 check_pop();
      @(posedge CLK); #1 check_pop();
    end

    // Several cycles of CLK with a steady lw: strobes follow both edges.
    @(negedge CLK);
    drive(lw_v);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) sb_q.push_back(lw_v);
      @(posedge CLK); #1 check_pop();
      sb_q.push_back(lw_v);
      @(negedge CLK); #1 check_pop();
    end

    // Asynchronous reset mid high phase with a valid load.
    @(posedge CLK); #2;
    chk("pre_reset_rd_clk", {31'd0, rd_clk}, 32'd1);
    drive(vecs[9]);
    #1 check_pop();
    chk("reset_rd_addr_held", {27'd0, rd_addr}, 32'd16);
    // Release while CLK still high: writeback strobe returns at once.
    drive(lw_v);
    #1 check_pop();
    chk("release_rd_clk", {31'd0, rd_clk}, 32'd1);
    sb_q.push_back(lw_v);
    @(negedge CLK); #1 check_pop();

    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
